// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding valid/ready transaction, byte/half/word access to a local word array.
// Optional build macro DMEM_MISALIGN_ERR_EN: misaligned half/word accesses fault instead of being force-aligned.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          fault;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rmask;
  logic [31:0]   rd_next;
  logic          exec;

  // Decode works on the captured request, so req_* only matter at the accept edge.
  always_comb begin
    off      = cap_addr - BASE_ADDR;
    in_range = {1'b0, off} < SPAN;
    idx      = off[AW+1:2];
    lane     = cap_addr[1:0];
    fault    = !in_range;
    be       = '0;
    wword    = '0;
    rmask    = '0;
    case (cap_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{cap_wdata[7:0]}};
        rmask = 32'h0000_00FF;
      end
      2'b01: begin
`ifdef DMEM_MISALIGN_ERR_EN
        if (cap_addr[0]) fault = 1'b1;
`endif
        lane  = {cap_addr[1], 1'b0};
        be    = 4'b0011 << lane;
        wword = {2{cap_wdata[15:0]}};
        rmask = 32'h0000_FFFF;
      end
      2'b10: begin
`ifdef DMEM_MISALIGN_ERR_EN
        if (cap_addr[1:0] != 2'b00) fault = 1'b1;
`endif
        lane  = 2'b00;
        be    = '1;
        wword = cap_wdata;
        rmask = '1;
      end
      default: fault = 1'b1;
    endcase
    if (fault) be = '0;
    rd_next = '0;
    if (!fault && !cap_write) rd_next = (mem[idx] >> {lane, 3'b000}) & rmask;
  end

  // The WAIT state always runs at least one cycle and leaves once the counter is
  // exhausted, giving 1+WAIT_CYCLES cycles from accept to response.
  assign exec = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (exec && cap_write && !rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_size  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_size  <= req_size;
            cnt       <= WAIT_LOAD;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_next;
            rsp_err   <= fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus stall and mid-transaction reset sequences.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rv1 = 1'b0, rv3 = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rsp_ready = 1'b1;

  logic        r1_ready, r1_valid, r1_err;
  logic [31:0] r1_rdata;
  logic        r3_ready, r3_valid, r3_err;
  logic [31:0] r3_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(r1_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .rsp_valid(r1_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(r1_rdata), .rsp_err(r1_err));

  dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(r3_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .rsp_valid(r3_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(r3_rdata), .rsp_err(r3_err));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;
  bit   sel    = 1'b0;

  function automatic logic o_ready();        return sel ? r3_ready : r1_ready; endfunction
  function automatic logic o_valid();        return sel ? r3_valid : r1_valid; endfunction
  function automatic logic o_err();          return sel ? r3_err   : r1_err;   endfunction
  function automatic logic [31:0] o_rdata(); return sel ? r3_rdata : r1_rdata; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, output logic [31:0] rdata, output logic err,
                     output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_ready() && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("req_ready_timeout", 32'(o_ready()), 32'd1);
    req_write = wr; req_addr = addr; req_wdata = wdata; req_size = size;
    rsp_ready = 1'b1;
    if (sel) rv3 = 1'b1; else rv1 = 1'b1;
    @(posedge clk);
    #1;
    rv1 = 1'b0; rv3 = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!o_valid() && lat < 50);
    rdata = o_rdata();
    err   = o_err();
    @(posedge clk);
    #1;
    check("valid_drops_after_handshake", 32'(o_valid()), 32'd0);
    check("ready_after_handshake", 32'(o_ready()), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd, stall_rd, w1, w2;
    logic        er;
    int          lat;

    w1 = MIS ? 32'h5522_3344 : 32'h5522_ABCD;
    w2 = MIS ? 32'hBEEF_3344 : 32'hBEEF_ABCD;
    add(1, 32'h8000_0000, 32'hA5A5_0001, 2'b10, 32'h0, 0);
    add(1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         2'b10, 32'hDEAD_BEEF, 0);
    add(1, 32'h8000_0010, 32'h1122_3344, 2'b10, 32'h0, 0);
    add(1, 32'h8000_0013, 32'hFFFF_FF55, 2'b00, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         2'b10, 32'h5522_3344, 0);
    add(0, 32'h8000_0012, 32'h0,         2'b00, 32'h0000_0022, 0);
    add(0, 32'h8000_0012, 32'h0,         2'b01, 32'h0000_5522, 0);
    add(0, 32'h8000_0013, 32'h0,         2'b00, 32'h0000_0055, 0);
    add(0, 32'h7FFF_FFFC, 32'h0,         2'b10, 32'h0, 1);
    add(1, 32'h8000_4000, 32'hFFFF_FFFF, 2'b10, 32'h0, 1);
    add(0, 32'h8000_0000, 32'h0,         2'b10, 32'hA5A5_0001, 0);
    add(1, 32'h8000_3FFC, 32'h0BAD_F00D, 2'b10, 32'h0, 0);
    add(0, 32'h8000_3FFC, 32'h0,         2'b10, 32'h0BAD_F00D, 0);
    add(0, 32'h8000_0010, 32'h0,         2'b11, 32'h0, 1);
    add(1, 32'h8000_0011, 32'h0000_ABCD, 2'b01, 32'h0, MIS);
    add(0, 32'h8000_0012, 32'h0,         2'b10, MIS ? 32'h0 : w1, MIS);
    add(0, 32'h8000_0011, 32'h0,         2'b01, MIS ? 32'h0 : 32'h0000_ABCD, MIS);
    add(1, 32'h8000_0012, 32'h1234_BEEF, 2'b01, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         2'b10, w2, 0);
    add(0, 32'h8000_0012, 32'h0,         2'b01, 32'h0000_BEEF, 0);

    #1 rst = 1'b1;
    #2;
    check("reset_req_ready", 32'(r1_ready), 32'd1);
    check("reset_rsp_valid", 32'(r1_valid), 32'd0);
    check("reset_rsp_rdata", r1_rdata, 32'h0);
    check("reset_rsp_err",   32'(r1_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Response backpressure: a competing request must not be taken while stalled.
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h8000_0010; req_size = 2'b10;
    rsp_ready = 1'b0; rv1 = 1'b1;
    @(posedge clk);
    #1 rv1 = 1'b0;
    lat = 0;
    while (!r1_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    check("stall_latency", 32'(lat), 32'd2);
    stall_rd = r1_rdata;
    check("stall_rdata", stall_rd, w2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_size = 2'b10; rv1 = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", c), 32'(r1_valid), 32'd1);
      check($sformatf("stall%0d_rdata", c), r1_rdata, w2);
      check($sformatf("stall%0d_req_ready", c), 32'(r1_ready), 32'd0);
    end
    @(negedge clk);
    rv1 = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_valid", 32'(r1_valid), 32'd0);
    check("stall_release_ready", 32'(r1_ready), 32'd1);
    txn(0, 32'h8000_0010, 32'h0, 2'b10, rd, er, lat);
    check("stall_no_store_taken", rd, w2);

    // Mid-transaction reset on the 3-wait-state instance.
    sel = 1'b1;
    txn(1, 32'h8000_0020, 32'h1234_5678, 2'b10, rd, er, lat);
    check("w3_store_latency", 32'(lat), 32'd4);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D; req_size = 2'b10;
    rv3 = 1'b1;
    @(posedge clk);
    #1 rv3 = 1'b0;
    check("w3_accepted", 32'(r3_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(r3_ready), 32'd1);
    check("midrst_rsp_valid", 32'(r3_valid), 32'd0);
    check("midrst_rsp_rdata", r3_rdata, 32'h0);
    check("midrst_rsp_err",   32'(r3_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 32'h8000_0020, 32'h0, 2'b10, rd, er, lat);
    check("midrst_old_contents", rd, 32'h1234_5678);
    check("midrst_load_err", 32'(er), 32'd0);
    check("w3_load_latency", 32'(lat), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
